fp16_mul_axis: RTL and testbench

- Synthesizable IEEE-754 binary16 multiplier that sits on the slave (responder) side of the two-operand AXI-Stream interface used by the float datapath.
- Joins an A stream and a B stream and returns their product on a master result stream with full tready backpressure.
- Serves as the in-house replacement for the vendor multiply core, with a fixed and documented latency and exception behaviour.

---
 rtl/fp16_pkg.sv | 35 +++
 rtl/fp16_round_pack.sv | 74 +++++++
 rtl/fp16_mul_axis.sv | 161 ++++++++++++++++
 tb/tb_fp16_mul_axis.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared types and constants for the binary16 multiply datapath.
//   fp16_t        - packed binary16 view {sign, exp, mant}
//   fp_class_e    - operand/result class (subnormals are folded into ZERO)
//   fp16_classify - maps a binary16 value onto fp_class_e
package fp16_pkg;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] mant;
    } fp16_t;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    localparam int          EXP_BIAS  = 15;
    localparam int          EXP_MAX   = 31;
    localparam logic [15:0] FP16_PINF = 16'h7C00;

    // Subnormals classify as ZERO: the datapath flushes them to signed zero.
    function automatic fp_class_e fp16_classify(input fp16_t x);
        if (x.exp == 5'd0) begin
            return ZERO;
        end else if (x.exp == 5'h1F) begin
            return (x.mant == 10'd0) ? INF : NAN;
        end else begin
            return NORM;
        end
    endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// fp16_round_pack: combinational normalize / round-to-nearest-even / pack of a
// binary16 product.
//   prod_i   - 22-bit product of two 11-bit significands (hidden 1 included)
//   exp_i    - biased exponent sum ea + eb - bias, signed
//   sign_i   - result sign
//   cls_i    - result class already resolved for specials
//   result_o - packed binary16 result (flush-to-zero, no subnormal outputs)
module fp16_round_pack
    import fp16_pkg::*;
#(
    parameter logic [15:0] CANON_NAN = 16'h7E00
) (
    input  logic [21:0]       prod_i,
    input  logic signed [6:0] exp_i,
    input  fp_class_e         cls_i,
    input  logic              sign_i,
    output logic [15:0]       result_o
);

    logic [9:0]        mant_raw;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [11:0]       sig_rnd;
    logic [9:0]        mant_fin;
    logic signed [7:0] exp_norm;
    logic signed [7:0] exp_fin;

    always_comb begin
        // Operands are in [1,2), so the product's leading one is bit 21 or 20.
        if (prod_i[21]) begin
            mant_raw = prod_i[20:11];
            guard    = prod_i[10];
            sticky   = |prod_i[9:0];
            exp_norm = {exp_i[6], exp_i} + 8'sd1;
        end else begin
            mant_raw = prod_i[19:10];
            guard    = prod_i[9];
            sticky   = |prod_i[8:0];
            exp_norm = {exp_i[6], exp_i};
        end

        round_up = guard & (sticky | mant_raw[0]);
        sig_rnd  = {2'b01, mant_raw} + {11'd0, round_up};

        // Carry out of the significand: value is exactly 2.0, mantissa wraps to 0.
        if (sig_rnd[11]) begin
            mant_fin = sig_rnd[10:1];
            exp_fin  = exp_norm + 8'sd1;
        end else begin
            mant_fin = sig_rnd[9:0];
            exp_fin  = exp_norm;
        end
    end

    always_comb begin
        result_o = {sign_i, 15'd0};
        unique case (cls_i)
            NAN:  result_o = CANON_NAN;
            INF:  result_o = {sign_i, FP16_PINF[14:0]};
            ZERO: result_o = {sign_i, 15'd0};
            NORM: begin
                if (int'(exp_fin) >= EXP_MAX) begin
                    result_o = {sign_i, FP16_PINF[14:0]};
                end else if (int'(exp_fin) <= 0) begin
                    result_o = {sign_i, 15'd0};
                end else begin
                    result_o = {sign_i, exp_fin[4:0], mant_fin};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp16_mul_axis.sv
// fp16_mul_axis: three-stage binary16 multiplier joining two AXI-Stream operand
// streams into one result stream.
//   aclk, aresetn          - clock, asynchronous active-low reset
//   s_axis_a_*             - operand A stream (tvalid/tready/tdata)
//   s_axis_b_*             - operand B stream (tvalid/tready/tdata)
//   m_axis_result_*        - product stream (tvalid/tready/tdata)
// Stages: S1 unpack/classify, S2 11x11 multiply, S3 round/pack into the output
// register. The result is registered on the third rising edge counting the
// consuming edge. The whole pipeline advances together, so bubbles also stall.
module fp16_mul_axis
    import fp16_pkg::*;
#(
    parameter logic [15:0] CANON_NAN = 16'h7E00
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_axis_a_tvalid,
    output logic        s_axis_a_tready,
    input  logic [15:0] s_axis_a_tdata,
    input  logic        s_axis_b_tvalid,
    output logic        s_axis_b_tready,
    input  logic [15:0] s_axis_b_tdata,
    output logic        m_axis_result_tvalid,
    input  logic        m_axis_result_tready,
    output logic [15:0] m_axis_result_tdata
);

    fp16_t     opa;
    fp16_t     opb;
    fp_class_e cls_a;
    fp_class_e cls_b;
    fp_class_e cls_res;
    logic      adv;
    logic      pair_valid;
    logic [15:0] rp_result;

    // S1 registers
    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q, s1_sign_d;
    logic signed [6:0] s1_exp_q, s1_exp_d;
    logic [10:0]       s1_sig_a_q, s1_sig_a_d;
    logic [10:0]       s1_sig_b_q, s1_sig_b_d;
    fp_class_e         s1_cls_q, s1_cls_d;
    // S2 registers
    logic              s2_valid_q, s2_valid_d;
    logic              s2_sign_q, s2_sign_d;
    logic signed [6:0] s2_exp_q, s2_exp_d;
    logic [21:0]       s2_prod_q, s2_prod_d;
    fp_class_e         s2_cls_q, s2_cls_d;
    // S3 / output registers
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_data_q, out_data_d;

    assign opa        = fp16_t'(s_axis_a_tdata);
    assign opb        = fp16_t'(s_axis_b_tdata);
    assign cls_a      = fp16_classify(opa);
    assign cls_b      = fp16_classify(opb);
    assign adv        = ~out_valid_q | m_axis_result_tready;
    assign pair_valid = s_axis_a_tvalid & s_axis_b_tvalid;

    // Each ready depends on the other side's valid so a lone operand is never taken.
    assign s_axis_a_tready = aresetn & adv & s_axis_b_tvalid;
    assign s_axis_b_tready = aresetn & adv & s_axis_a_tvalid;

    // Specials resolved up front; NaN outranks inf x zero, which outranks inf, then zero.
    always_comb begin
        cls_res = NORM;
        if (cls_a == NAN || cls_b == NAN) begin
            cls_res = NAN;
        end else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
            cls_res = NAN;
        end else if (cls_a == INF || cls_b == INF) begin
            cls_res = INF;
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            cls_res = ZERO;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_exp_d    = s1_exp_q;
        s1_sig_a_d  = s1_sig_a_q;
        s1_sig_b_d  = s1_sig_b_q;
        s1_cls_d    = s1_cls_q;
        s2_valid_d  = s2_valid_q;
        s2_sign_d   = s2_sign_q;
        s2_exp_d    = s2_exp_q;
        s2_prod_d   = s2_prod_q;
        s2_cls_d    = s2_cls_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (adv) begin
            s1_valid_d  = pair_valid;
            s1_sign_d   = opa.sign ^ opb.sign;
            s1_exp_d    = $signed({2'b00, opa.exp}) + $signed({2'b00, opb.exp})
                          - 7'(EXP_BIAS);
            s1_sig_a_d  = {1'b1, opa.mant};
            s1_sig_b_d  = {1'b1, opb.mant};
            s1_cls_d    = cls_res;

            s2_valid_d  = s1_valid_q;
            s2_sign_d   = s1_sign_q;
            s2_exp_d    = s1_exp_q;
            s2_prod_d   = {11'd0, s1_sig_a_q} * {11'd0, s1_sig_b_q};
            s2_cls_d    = s1_cls_q;

            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_data_d = rp_result;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_sig_a_q  <= '0;
            s1_sig_b_q  <= '0;
            s1_cls_q    <= ZERO;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            s2_cls_q    <= ZERO;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_sig_a_q  <= s1_sig_a_d;
            s1_sig_b_q  <= s1_sig_b_d;
            s1_cls_q    <= s1_cls_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_exp_q    <= s2_exp_d;
            s2_prod_q   <= s2_prod_d;
            s2_cls_q    <= s2_cls_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    fp16_round_pack #(
        .CANON_NAN (CANON_NAN)
    ) u_round_pack (
        .prod_i   (s2_prod_q),
        .exp_i    (s2_exp_q),
        .cls_i    (s2_cls_q),
        .sign_i   (s2_sign_q),
        .result_o (rp_result)
    );

    assign m_axis_result_tvalid = out_valid_q;
    assign m_axis_result_tdata  = out_data_q;

endmodule

// File: tb/tb_fp16_mul_axis.sv
// Directed bench for fp16_mul_axis: reset state, arithmetic vectors with
// hand-computed products, backpressure, join skew and reset mid-flight.
module tb_fp16_mul_axis;

    logic        aclk;
    logic        aresetn;
    logic        a_valid, a_ready;
    logic [15:0] a_data;
    logic        b_valid, b_ready;
    logic [15:0] b_data;
    logic        o_valid, m_ready;
    logic [15:0] o_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] kval [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                              16'h4500, 16'h4600, 16'h4700, 16'h4800};

    fp16_mul_axis #(
        .CANON_NAN (16'h7E00)
    ) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .s_axis_a_tvalid      (a_valid),
        .s_axis_a_tready      (a_ready),
        .s_axis_a_tdata       (a_data),
        .s_axis_b_tvalid      (b_valid),
        .s_axis_b_tready      (b_ready),
        .s_axis_b_tdata       (b_data),
        .m_axis_result_tvalid (o_valid),
        .m_axis_result_tready (m_ready),
        .m_axis_result_tdata  (o_data)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pair with tready high: consumed on edge E0, result valid after E2 only.
    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp);
        m_ready = 1'b1;
        a_data  = a;
        b_data  = b;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        chk($sformatf("%s_rdy", tag), {15'd0, a_ready & b_ready}, 16'd1);
        tick();                                     // E0: consuming edge
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();                                     // E1
        chk($sformatf("%s_early", tag), {15'd0, o_valid}, 16'd0);
        tick();                                     // E2
        chk($sformatf("%s_valid", tag), {15'd0, o_valid}, 16'd1);
        chk($sformatf("%s_data", tag), o_data, exp);
        tick();                                     // E3: single beat only
        chk($sformatf("%s_drop", tag), {15'd0, o_valid}, 16'd0);
    endtask

    int sent, recv, rdy_bad, beats, bad;
    logic stall_prev;
    logic [15:0] held, last;

    initial begin
        aresetn = 1'b0;
        m_ready = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 16'h3C00;
        b_data  = 16'h3C00;
        #2;
        chk("rst_tvalid", {15'd0, o_valid}, 16'd0);
        chk("rst_tdata", o_data, 16'h0000);
        chk("rst_ardy", {15'd0, a_ready}, 16'd0);
        chk("rst_brdy", {15'd0, b_ready}, 16'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        #10 aresetn = 1'b1;
        tick();

        // Tie 633.5 -> 634 under round-to-even.
        run_one("target", 16'hB600, 16'h7451, 16'hEE7A);
        run_one("ident", 16'h3C00, 16'h3C00, 16'h3C00);
        run_one("ovf_pos", 16'h7BFF, 16'h7BFF, 16'h7C00);
        run_one("ovf_neg", 16'hFBFF, 16'h7BFF, 16'hFC00);
        run_one("inf_x_zero", 16'h7C00, 16'h0000, 16'h7E00);
        run_one("nan_in", 16'h7E01, 16'h3C00, 16'h7E00);
        run_one("underflow", 16'h0400, 16'h0400, 16'h0000);
        run_one("subnorm", 16'h0001, 16'h3C00, 16'h0000);
        run_one("inf_x_fin", 16'hFC00, 16'h4000, 16'hFC00);
        run_one("neg_zero", 16'h8000, 16'h4000, 16'h8000);

        // Backpressure: 8 back-to-back pairs, tready pattern 1,0,0,1.
        sent = 0; recv = 0; rdy_bad = 0; stall_prev = 1'b0; held = '0;
        for (int c = 0; c < 200 && recv < 8; c++) begin
            m_ready = (c % 4 == 0) || (c % 4 == 3);
            a_valid = (sent < 8);
            b_valid = (sent < 8);
            a_data  = 16'h3C00;
            b_data  = kval[(sent < 8) ? sent : 7];
            #1;
            if (stall_prev) chk("bp_hold", o_data, held);
            if (o_valid && !m_ready) begin
                if (a_ready || b_ready) rdy_bad++;
                held       = o_data;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (o_valid && m_ready) begin
                chk($sformatf("bp_beat%0d", recv), o_data, kval[recv]);
                recv++;
            end
            if (a_valid && b_valid && a_ready && b_ready) sent++;
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        m_ready = 1'b1;
        chk("bp_recv", 16'(recv), 16'd8);
        chk("bp_sent", 16'(sent), 16'd8);
        chk("bp_rdy_low", 16'(rdy_bad), 16'd0);
        for (int i = 0; i < 4; i++) tick();

        // Join skew: A alone for 5 cycles, then B joins.
        a_data = 16'h4000;
        b_data = 16'h4200;
        a_valid = 1'b1;
        b_valid = 1'b0;
        bad = 0; beats = 0; last = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (a_ready) bad++;
            if (o_valid) beats++;
            tick();
        end
        chk("skew_ardy_low", 16'(bad), 16'd0);
        b_valid = 1'b1;
        #1;
        chk("skew_ardy_high", {15'd0, a_ready}, 16'd1);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (o_valid) begin
                beats++;
                last = o_data;
            end
            tick();
        end
        chk("skew_beats", 16'(beats), 16'd1);
        chk("skew_data", last, 16'h4600);

        // Reset with three pairs in flight.
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data  = 16'h4000;
            b_data  = kval[i];
            a_valid = 1'b1;
            b_valid = 1'b1;
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        chk("rmf_inflight", {15'd0, o_valid}, 16'd1);
        aresetn = 1'b0;
        #1;
        chk("rmf_tvalid", {15'd0, o_valid}, 16'd0);
        chk("rmf_tdata", o_data, 16'h0000);
        tick();
        tick();
        #2 aresetn = 1'b1;
        m_ready = 1'b1;
        beats = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_valid) beats++;
        end
        chk("rmf_no_stale", 16'(beats), 16'd0);
        run_one("rmf_after", 16'h4200, 16'h4200, 16'h4880);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
